// File: rtl/cmp_mon_pkg.sv
// Shared types and constants for the comparator flag monitor.
// Flags are packed {g, e, s}; a legal sample is exactly one of them.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [2:0] FLAG_G = 3'b100;
    localparam logic [2:0] FLAG_E = 3'b010;
    localparam logic [2:0] FLAG_S = 3'b001;

    function automatic logic is_one_hot(input logic [2:0] flags);
        return (flags == FLAG_G) || (flags == FLAG_E) || (flags == FLAG_S);
    endfunction

endpackage

// File: rtl/cmp_flag_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Synchronous active-low reset and soft clear both return it to zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written only with <= so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cmp_flag_monitor.sv
// Qualifies comparator g/e/s flags, drives a hysteresis alarm on "a > b",
// and keeps saturating per-outcome statistics plus a sticky illegal-flag error.
module cmp_flag_monitor
    import cmp_mon_pkg::*;
#(
    parameter int SET_COUNT = 4,
    parameter int CLR_COUNT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             g,
    input  logic             e,
    input  logic             s,
    output logic             alarm,
    output logic [CNT_W-1:0] streak,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             err
);

    localparam logic [CNT_W-1:0] SET_TARGET = CNT_W'(SET_COUNT);
    localparam logic [CNT_W-1:0] CLR_TARGET = CNT_W'(CLR_COUNT);

    logic [2:0]       flags;
    logic             sample_en;
    logic             legal_sample;
    logic             illegal_sample;
    logic             hit_g;
    logic             hit_e;
    logic             hit_s;
    logic             hit_not_g;
    logic [CNT_W-1:0] streak_inc;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] next_streak;
    logic             next_alarm;

    // A clear in the same cycle as a valid sample discards the sample.
    assign flags          = {g, e, s};
    assign sample_en      = in_valid && !clear;
    assign legal_sample   = sample_en && is_one_hot(flags);
    assign illegal_sample = sample_en && !is_one_hot(flags);
    assign hit_g          = legal_sample && (flags == FLAG_G);
    assign hit_e          = legal_sample && (flags == FLAG_E);
    assign hit_s          = legal_sample && (flags == FLAG_S);
    assign hit_not_g      = hit_e || hit_s;
    assign streak_inc     = streak + CNT_W'(1);

    // State register; alarm is registered from the decoded next state so it
    // changes exactly one cycle after the deciding sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
            alarm  <= 1'b0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
            alarm  <= next_alarm;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        next_state  = state;
        next_streak = streak;
        if (clear) begin
            next_state  = IDLE;
            next_streak = '0;
        end else if (legal_sample) begin
            case (state)
                IDLE: begin
                    if (hit_g) begin
                        if (SET_COUNT == 1) begin
                            next_state  = ALARM;
                            next_streak = '0;
                        end else begin
                            next_state  = ARMING;
                            next_streak = CNT_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (hit_g) begin
                        if (streak_inc == SET_TARGET) begin
                            next_state  = ALARM;
                            next_streak = '0;
                        end else begin
                            next_streak = streak_inc;
                        end
                    end else begin
                        next_state  = IDLE;
                        next_streak = '0;
                    end
                end
                ALARM: begin
                    if (hit_not_g) begin
                        if (CLR_COUNT == 1) begin
                            next_state  = IDLE;
                            next_streak = '0;
                        end else begin
                            next_state  = RELEASING;
                            next_streak = CNT_W'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (hit_not_g) begin
                        if (streak_inc == CLR_TARGET) begin
                            next_state  = IDLE;
                            next_streak = '0;
                        end else begin
                            next_streak = streak_inc;
                        end
                    end else begin
                        next_state  = ALARM;
                        next_streak = '0;
                    end
                end
                default: begin
                    next_state  = IDLE;
                    next_streak = '0;
                end
            endcase
        end
    end

    always_comb begin
        next_alarm = (next_state == ALARM) || (next_state == RELEASING);
    end

    // Sticky error: only reset or clear can lower it.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err <= 1'b0;
        end else if (illegal_sample) begin
            err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (hit_g),
        .q     (gt_count)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (hit_e),
        .q     (eq_count)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (hit_s),
        .q     (lt_count)
    );

endmodule

// File: doc/cmp_flag_monitor.md
Name: cmp_flag_monitor

Overview:
- Downstream consumer of the 4-bit comparator's one-hot result flags (g, e, s).
- Qualifies each sample with a valid strobe and applies set/clear hysteresis to raise a registered "a greater than b" alarm.
- Keeps saturating per-outcome statistics and a sticky error flag for illegal flag combinations.
- Sits between the comparator and the status/control logic that reads the alarm and counts.

Parameters:
- SET_COUNT, 4: consecutive valid g samples needed to raise alarm (1 .. 2^CNT_W-1).
- CLR_COUNT, 2: consecutive valid non-g samples (e or s) needed to drop alarm (1 .. 2^CNT_W-1).
- CNT_W, 8: width of the streak and statistics counters.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous soft clear of FSM, counters and err.
- in_valid  in  1  g/e/s are sampled only when high.
- g  in  1  comparator a > b.
- e  in  1  comparator a == b.
- s  in  1  comparator a < b.
- alarm  out  1  hysteresis output, registered.
- streak  out  CNT_W  current run length in ARMING/RELEASING; 0 otherwise.
- gt_count  out  CNT_W  legal valid g samples, saturating.
- eq_count  out  CNT_W  legal valid e samples, saturating.
- lt_count  out  CNT_W  legal valid s samples, saturating.
- err  out  1  sticky: a valid sample was not exactly one-hot.

Behaviour:
- Reset: rst_n low at a clk edge sets state IDLE. All of alarm, streak, gt/eq/lt_count and err go to 0. Reset overrides clear and in_valid.
- clear: same effect as reset, one cycle, registered. clear and in_valid in the same cycle: clear wins and the sample is discarded.
- Legal sample: in_valid=1 and {g,e,s} is exactly one-hot.
- Illegal sample: in_valid=1 with zero or several of g/e/s set. Sets err=1 next cycle. FSM, streak and counts are unchanged.
- in_valid=0: everything holds.
- Counters: each legal sample increments its outcome counter. At 2^CNT_W-1 a counter holds (no wrap).
- FSM states: IDLE, ARMING, ALARM, RELEASING. alarm is registered and equals 1 in ALARM or RELEASING. Latency from the deciding sample to the alarm change is 1 cycle.
- IDLE, legal g:
  - SET_COUNT==1: go to ALARM, streak=0.
  - otherwise: go to ARMING, streak=1.
- IDLE, legal e/s: stay.
- ARMING, legal g: streak+1. If that equals SET_COUNT, go to ALARM with streak=0.
- ARMING, legal e/s: go to IDLE, streak=0.
- ALARM, legal g: stay.
- ALARM, legal e/s:
  - CLR_COUNT==1: go to IDLE, streak=0.
  - otherwise: go to RELEASING, streak=1.
- RELEASING, legal e/s: streak+1. If that equals CLR_COUNT, go to IDLE with streak=0.
- RELEASING, legal g: go to ALARM, streak=0.
- streak never exceeds max(SET_COUNT, CLR_COUNT)-1 when observed.
- Mid-run reset or clear: any partial streak is lost, no alarm glitch. An alarm that was high goes low the cycle after.

Decomposition:
- Package cmp_mon_pkg holds:
  - state_t enum {IDLE, ARMING, ALARM, RELEASING};
  - one-hot flag constants FLAG_G=3'b100, FLAG_E=3'b010, FLAG_S=3'b001.
- Sub-module sat_counter (param W; ports clk, rst_n, clr, inc, q), instantiated three times for gt/eq/lt.

Test Plan (SET_COUNT=4, CLR_COUNT=2, CNT_W=8):
- Reset: hold rst_n=0 two cycles with in_valid=1, g=1 -> all outputs 0. Release, apply 4 valid g (a=14, b=8) -> alarm=1 in the cycle after the 4th, gt_count=4.
- Broken arming: 3 valid g then 1 valid e (a=5, b=5) -> streak 1,2,3 then 0, alarm stays 0, eq_count=1.
- Hysteresis: from alarm=1, apply s, g, s, s (a=2, b=10 for s) -> alarm drops only after the final two consecutive s, lt_count=3.
- Gaps and illegal flags: in_valid toggles 1,0,1 with g, then in_valid=1 and g=e=1 -> streak counts only valid legal samples, err=1 sticky, no counter changes on the illegal sample.
- Saturation: 300 valid e samples -> eq_count holds at 255.
- Clear collisions: clear with a valid g in the same cycle while in ARMING -> state IDLE, streak=0, gt_count=0, err=0. Separately, rst_n=0 while alarm=1 -> alarm 0 next cycle.
